eng_seq_ctrl: RTL and testbench
===============================

# eng_seq_ctrl

Sequencer for `engine_top` that runs one complete encode job. From host parameters (k, packet count), it pulses an engine-local reset and derives and writes the BMU mux-select and XOR-tree AND-mask registers. It then gates `cntrl_eng_calc_en` against the input and output buffer status and counts consumed packets. Finally it drains the engine pipeline and signals completion. It sits between the host/CSR block and `engine_top`.

## Interface
- K_MAX, 4, largest supported k
- K_MIN, 2, smallest supported k
- BM_MULT_UNIT_NUM, 4, number of BMUs in the engine
- PCK_TREE_XOR_UNITS_NUM, BM_MULT_UNIT_NUM/K_MIN, number of XOR-tree units
- BMU_BM_MUX_SEL_W, $clog2(K_MAX), width of each mux select
- K_W, $clog2(K_MAX+1), width of the k field
- PKT_CNT_W, 16, width of the packet counter
- DRAIN_TIMEOUT, 64, drain watchdog limit in cycles (used only with the macro)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- abort  in  1  synchronous job abort
- k_cfg  in  K_W  data-packet count k
- num_pkts  in  PKT_CNT_W  packets to consume
- inbuf_eng_din_reg_val  in  1  input buffer data valid
- cntl_eng_bm_col_din_reg_val  in  1  bit-matrix column valid
- outbuf_eng_full  in  1  output buffer full
- data_used  in  1  engine consumed one packet this cycle
- eng_pl_empty  in  1  engine pipeline empty
- eng_rstn  out  1  engine-local reset, active-low
- bmu_bm_mux_sel_reg_wr  out  1  mux-select register write strobe
- bmu_bm_mux_sel_reg_din  out  [BMU_BM_MUX_SEL_W-1:0] x BM_MULT_UNIT_NUM  mux-select values
- and_mask_mask_reg_wr  out  1  mask register write strobe
- and_mask_mask_reg_din  out  [0:K_MAX-1] x PCK_TREE_XOR_UNITS_NUM  mask values
- cntrl_eng_calc_en  out  1  engine calculate enable
- global_reg_wr_en  out  1  engine global register enable
- busy  out  1  job in progress
- done  out  1  job-complete pulse
- err  out  1  sticky error flag
- pkt_cnt  out  PKT_CNT_W  packets consumed in the current job

## Operation
- States: IDLE, CLR, CFG, RUN, DRAIN, DONE.
- IDLE: on `start`, the job is checked. k_cfg must be in [K_MIN, K_MAX], must divide BM_MULT_UNIT_NUM, and num_pkts must be nonzero.
  - Valid job: latch k and num_pkts, clear pkt_cnt, go to CLR.
  - Invalid job: set `err`, stay in IDLE.
- CLR: `eng_rstn`=0 for exactly 1 cycle, then go to CFG.
- CFG: both write strobes are high for exactly 1 cycle, then go to RUN.
  - Mux select for BMU i is `i % k`.
  - Mask for XOR unit j is the low k bits set when `j < BM_MULT_UNIT_NUM/k`; otherwise all zero.
  - The din buses hold their values from CFG until the next CFG.
- RUN: `cntrl_eng_calc_en` = both valids & !outbuf_eng_full.
  - `global_reg_wr_en` = `cntrl_eng_calc_en`.
  - Each `data_used` increments pkt_cnt.
  - When `data_used` fires with pkt_cnt == num_pkts-1, go to DRAIN. calc_en is 0 from that cycle onward.
- DRAIN: calc_en=0. When `eng_pl_empty`=1, go to DONE.
- DONE: `done`=1 for 1 cycle, then go to IDLE.
- `abort` in any non-IDLE state: the next state is IDLE and `eng_rstn` pulses low for 1 cycle. `done` is not raised. pkt_cnt holds its value.
- `start` outside IDLE is ignored. `err` is cleared only by a valid start.
- `data_used` outside RUN is ignored and does not change pkt_cnt.

## Timing
- Reset values: state IDLE; eng_rstn=0 while rst_n is low; all strobes, busy, done, err and calc_en are 0; pkt_cnt=0; din buses are 0.
- `cntrl_eng_calc_en` and `global_reg_wr_en` are combinational from registered state plus inputs, so backpressure has zero cycles of latency.
- All other outputs are registered.
- start sampled at edge t:
  - CLR (eng_rstn=0) during cycle t+1
  - CFG strobes during t+2
  - RUN from t+3
- `busy`=1 in every state except IDLE.
- `done` is asserted exactly 1 cycle after the cycle in which eng_pl_empty is seen in DRAIN.
- With outbuf_eng_full stuck at 1, the controller stays in RUN indefinitely. This is legal.

## Configuration
- `ENG_SEQ_TIMEOUT_EN` defined: DRAIN counts cycles. If DRAIN_TIMEOUT cycles elapse without eng_pl_empty:
  - set `err`
  - pulse eng_rstn low for 1 cycle
  - go to DONE
- Not defined: no counter; DRAIN waits forever for eng_pl_empty.

## Structure
- Shared package `eng_pkg`: the state enum `eng_seq_state_t`, and the default constants K_MAX, K_MIN, BM_MULT_UNIT_NUM and W.
- One sub-module, `eng_cfg_gen`: combinational derivation of the mux selects and masks from k, plus the k-validity check.

## Test plan
- k=2, num_pkts=3, valids high, full=0:
  - sel = {0,1,0,1}, masks = {0011, 0011}
  - strobes at t+2, exactly 3 data_used are counted
  - DRAIN entered, done 1 cycle after eng_pl_empty
- k=4: sel = {0,1,2,3}, masks = {1111, 0000}.
- k=3 or num_pkts=0: err=1, busy stays 0, no eng_rstn pulse.
- In RUN, toggle outbuf_eng_full and inbuf_eng_din_reg_val: calc_en follows in the same cycle and pkt_cnt stalls.
- abort mid-RUN: next cycle IDLE, eng_rstn low for 1 cycle, no done, pkt_cnt retained.
- With the macro, hold eng_pl_empty=0 in DRAIN: after 64 cycles err=1 and done pulses.

Source files
------------

// File: rtl/eng_pkg.sv
// Shared definitions for the engine sequencer: default geometry constants
// and the sequencer state encoding.
package eng_pkg;

  localparam int unsigned K_MAX                  = 4;
  localparam int unsigned K_MIN                  = 2;
  localparam int unsigned BM_MULT_UNIT_NUM       = 4;
  localparam int unsigned PCK_TREE_XOR_UNITS_NUM = BM_MULT_UNIT_NUM / K_MIN;
  localparam int unsigned BMU_BM_MUX_SEL_W       = $clog2(K_MAX);
  localparam int unsigned K_W                    = $clog2(K_MAX + 1);
  localparam int unsigned PKT_CNT_W              = 16;
  localparam int unsigned DRAIN_TIMEOUT          = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_CFG,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } eng_seq_state_t;

endpackage

// File: rtl/eng_cfg_gen.sv
// Combinational derivation of BMU mux selects and XOR-tree AND masks from k,
// plus the k-validity check. Every supported k is unrolled as a constant so
// no divider is synthesised.
module eng_cfg_gen #(
  parameter int unsigned K_MAX                  = eng_pkg::K_MAX,
  parameter int unsigned K_MIN                  = eng_pkg::K_MIN,
  parameter int unsigned BM_MULT_UNIT_NUM       = eng_pkg::BM_MULT_UNIT_NUM,
  parameter int unsigned PCK_TREE_XOR_UNITS_NUM = eng_pkg::PCK_TREE_XOR_UNITS_NUM,
  parameter int unsigned BMU_BM_MUX_SEL_W       = eng_pkg::BMU_BM_MUX_SEL_W,
  parameter int unsigned K_W                    = eng_pkg::K_W
) (
  input  logic [K_W-1:0]                                    k,
  output logic [BM_MULT_UNIT_NUM-1:0][BMU_BM_MUX_SEL_W-1:0] sel,
  output logic [PCK_TREE_XOR_UNITS_NUM-1:0][0:K_MAX-1]      mask,
  output logic                                              k_ok
);

  // Per-candidate-k table lookup of selects, masks and validity
  always_comb begin
    sel  = '0;
    mask = '0;
    k_ok = 1'b0;
    for (int unsigned d = K_MIN; d <= K_MAX; d++) begin
      if (k == K_W'(d)) begin
        k_ok = ((BM_MULT_UNIT_NUM % d) == 0);
        for (int unsigned i = 0; i < BM_MULT_UNIT_NUM; i++) begin
          sel[i] = BMU_BM_MUX_SEL_W'(i % d);
        end
        for (int unsigned j = 0; j < PCK_TREE_XOR_UNITS_NUM; j++) begin
          if (j < BM_MULT_UNIT_NUM / d) begin
            mask[j] = K_MAX'((1 << d) - 1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/eng_seq_ctrl.sv
// Encode-job sequencer for engine_top: engine reset, BMU/mask configuration,
// buffer-gated calculation, packet counting, pipeline drain and completion.
// Optional macro ENG_SEQ_TIMEOUT_EN adds a DRAIN watchdog that flags err and
// resets the engine if the pipeline never empties.
module eng_seq_ctrl #(
  parameter int unsigned K_MAX                  = eng_pkg::K_MAX,
  parameter int unsigned K_MIN                  = eng_pkg::K_MIN,
  parameter int unsigned BM_MULT_UNIT_NUM       = eng_pkg::BM_MULT_UNIT_NUM,
  parameter int unsigned PCK_TREE_XOR_UNITS_NUM = BM_MULT_UNIT_NUM / K_MIN,
  parameter int unsigned BMU_BM_MUX_SEL_W       = $clog2(K_MAX),
  parameter int unsigned K_W                    = $clog2(K_MAX + 1),
  parameter int unsigned PKT_CNT_W              = eng_pkg::PKT_CNT_W,
  parameter int unsigned DRAIN_TIMEOUT          = eng_pkg::DRAIN_TIMEOUT
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic                                              abort,
  input  logic [K_W-1:0]                                    k_cfg,
  input  logic [PKT_CNT_W-1:0]                              num_pkts,
  input  logic                                              inbuf_eng_din_reg_val,
  input  logic                                              cntl_eng_bm_col_din_reg_val,
  input  logic                                              outbuf_eng_full,
  input  logic                                              data_used,
  input  logic                                              eng_pl_empty,
  output logic                                              eng_rstn,
  output logic                                              bmu_bm_mux_sel_reg_wr,
  output logic [BM_MULT_UNIT_NUM-1:0][BMU_BM_MUX_SEL_W-1:0] bmu_bm_mux_sel_reg_din,
  output logic                                              and_mask_mask_reg_wr,
  output logic [PCK_TREE_XOR_UNITS_NUM-1:0][0:K_MAX-1]      and_mask_mask_reg_din,
  output logic                                              cntrl_eng_calc_en,
  output logic                                              global_reg_wr_en,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              err,
  output logic [PKT_CNT_W-1:0]                              pkt_cnt
);

  import eng_pkg::*;

  eng_seq_state_t state, state_nxt;

  logic [K_W-1:0]       k_q;
  logic [PKT_CNT_W-1:0] num_q;
  logic [K_W-1:0]       gen_k;
  logic                 gen_k_ok;
  logic                 job_ok;
  logic                 last_pkt;
  logic                 abort_hit;
  logic                 timeout_hit;

  logic [BM_MULT_UNIT_NUM-1:0][BMU_BM_MUX_SEL_W-1:0] gen_sel;
  logic [PCK_TREE_XOR_UNITS_NUM-1:0][0:K_MAX-1]      gen_mask;

  // One generator serves both the start-time check (k_cfg) and CFG (latched k)
  assign gen_k    = (state == ST_IDLE) ? k_cfg : k_q;
  assign job_ok   = gen_k_ok && (num_pkts != '0);
  assign last_pkt = data_used && (pkt_cnt == num_q - 1'b1);

  eng_cfg_gen #(
    .K_MAX                  (K_MAX),
    .K_MIN                  (K_MIN),
    .BM_MULT_UNIT_NUM       (BM_MULT_UNIT_NUM),
    .PCK_TREE_XOR_UNITS_NUM (PCK_TREE_XOR_UNITS_NUM),
    .BMU_BM_MUX_SEL_W       (BMU_BM_MUX_SEL_W),
    .K_W                    (K_W)
  ) u_cfg_gen (
    .k    (gen_k),
    .sel  (gen_sel),
    .mask (gen_mask),
    .k_ok (gen_k_ok)
  );

`ifdef ENG_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [TO_W-1:0] drain_cnt;
  logic            drain_expired;

  assign drain_expired = (drain_cnt == TO_W'(DRAIN_TIMEOUT - 1));

  // Cycles spent in DRAIN; zero on the first DRAIN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state == ST_DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
    end else begin
      drain_cnt <= '0;
    end
  end
`endif

  // Next-state logic; abort overrides every non-IDLE transition
  always_comb begin
    state_nxt   = state;
    abort_hit   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE:  if (start && job_ok) state_nxt = ST_CLR;
      ST_CLR:   state_nxt = ST_CFG;
      ST_CFG:   state_nxt = ST_RUN;
      ST_RUN:   if (last_pkt) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (eng_pl_empty) begin
          state_nxt = ST_DONE;
        end
`ifdef ENG_SEQ_TIMEOUT_EN
        else if (drain_expired) begin
          state_nxt   = ST_DONE;
          timeout_hit = 1'b1;
        end
`endif
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) begin
      state_nxt   = ST_IDLE;
      abort_hit   = 1'b1;
      timeout_hit = 1'b0;
    end
  end

  // Zero-latency backpressure gating of the engine enables
  always_comb begin
    cntrl_eng_calc_en = (state == ST_RUN) && inbuf_eng_din_reg_val &&
                        cntl_eng_bm_col_din_reg_val && !outbuf_eng_full;
    global_reg_wr_en  = cntrl_eng_calc_en;
  end

  // State register and registered outputs, decoded from the next state so
  // each output lines up with the cycle its state is occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= ST_IDLE;
      eng_rstn               <= 1'b0;
      bmu_bm_mux_sel_reg_wr  <= 1'b0;
      and_mask_mask_reg_wr   <= 1'b0;
      bmu_bm_mux_sel_reg_din <= '0;
      and_mask_mask_reg_din  <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      err                    <= 1'b0;
      pkt_cnt                <= '0;
      k_q                    <= '0;
      num_q                  <= '0;
    end else begin
      state                 <= state_nxt;
      eng_rstn              <= !((state_nxt == ST_CLR) || abort_hit || timeout_hit);
      bmu_bm_mux_sel_reg_wr <= (state_nxt == ST_CFG);
      and_mask_mask_reg_wr  <= (state_nxt == ST_CFG);
      busy                  <= (state_nxt != ST_IDLE);
      done                  <= (state_nxt == ST_DONE);

      if ((state == ST_IDLE) && start) begin
        if (job_ok) begin
          err     <= 1'b0;
          k_q     <= k_cfg;
          num_q   <= num_pkts;
          pkt_cnt <= '0;
        end else begin
          err <= 1'b1;
        end
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end

      if ((state == ST_RUN) && data_used && !abort_hit) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end

      if (state_nxt == ST_CFG) begin
        bmu_bm_mux_sel_reg_din <= gen_sel;
        and_mask_mask_reg_din  <= gen_mask;
      end
    end
  end

endmodule

// File: tb/tb_eng_seq_ctrl.sv
// Directed bench for eng_seq_ctrl with hand-computed expectations.
module tb_eng_seq_ctrl;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [2:0]      k_cfg;
  logic [15:0]     num_pkts;
  logic            inbuf_val;
  logic            col_val;
  logic            full;
  logic            data_used;
  logic            pl_empty;
  logic            eng_rstn;
  logic            sel_wr;
  logic [3:0][1:0] sel_din;
  logic            mask_wr;
  logic [1:0][0:3] mask_din;
  logic            calc_en;
  logic            gwr_en;
  logic            busy;
  logic            done;
  logic            err;
  logic [15:0]     pkt_cnt;

  int checks   = 0;
  int failures = 0;

  eng_seq_ctrl dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .start                       (start),
    .abort                       (abort),
    .k_cfg                       (k_cfg),
    .num_pkts                    (num_pkts),
    .inbuf_eng_din_reg_val       (inbuf_val),
    .cntl_eng_bm_col_din_reg_val (col_val),
    .outbuf_eng_full             (full),
    .data_used                   (data_used),
    .eng_pl_empty                (pl_empty),
    .eng_rstn                    (eng_rstn),
    .bmu_bm_mux_sel_reg_wr       (sel_wr),
    .bmu_bm_mux_sel_reg_din      (sel_din),
    .and_mask_mask_reg_wr        (mask_wr),
    .and_mask_mask_reg_din       (mask_din),
    .cntrl_eng_calc_en           (calc_en),
    .global_reg_wr_en            (gwr_en),
    .busy                        (busy),
    .done                        (done),
    .err                         (err),
    .pkt_cnt                     (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; k_cfg = '0; num_pkts = '0;
    inbuf_val = 1'b0; col_val = 1'b0; full = 1'b0; data_used = 1'b0; pl_empty = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_eng_rstn", eng_rstn, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_strobes", {sel_wr, mask_wr}, 0);
    check("rst_calc_en", calc_en, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_sel_din", sel_din, 0);
    check("rst_mask_din", mask_din, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_eng_rstn", eng_rstn, 1);

    // Job 1: k=2, 3 packets
    k_cfg = 3'd2; num_pkts = 16'd3; inbuf_val = 1'b1; col_val = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("j1_clr_eng_rstn", eng_rstn, 0);
    check("j1_clr_busy", busy, 1);
    check("j1_clr_strobes", {sel_wr, mask_wr}, 0);
    check("j1_clr_calc_en", calc_en, 0);
    tick();
    check("j1_cfg_eng_rstn", eng_rstn, 1);
    check("j1_cfg_strobes", {sel_wr, mask_wr}, 2'b11);
    check("j1_sel_din", sel_din, 8'h44);
    check("j1_mask_din", mask_din, 8'h33);
    check("j1_cfg_calc_en", calc_en, 0);
    tick();
    check("j1_run_strobes", {sel_wr, mask_wr}, 0);
    check("j1_run_calc_en", calc_en, 1);
    check("j1_run_gwr_en", gwr_en, 1);
    check("j1_run_pkt0", pkt_cnt, 0);
    data_used = 1'b1;
    tick();
    data_used = 1'b0;
    check("j1_pkt1", pkt_cnt, 1);
    full = 1'b1;
    #1;
    check("j1_full_calc_en", calc_en, 0);
    check("j1_full_gwr_en", gwr_en, 0);
    tick();
    check("j1_stall_pkt", pkt_cnt, 1);
    check("j1_stall_busy", busy, 1);
    full = 1'b0; inbuf_val = 1'b0;
    #1;
    check("j1_inval_calc_en", calc_en, 0);
    inbuf_val = 1'b1;
    #1;
    check("j1_resume_calc_en", calc_en, 1);
    data_used = 1'b1;
    tick();
    check("j1_pkt2", pkt_cnt, 2);
    tick();
    data_used = 1'b0;
    check("j1_pkt3", pkt_cnt, 3);
    check("j1_drain_calc_en", calc_en, 0);
    check("j1_drain_busy", busy, 1);
    data_used = 1'b1;
    tick();
    data_used = 1'b0;
    check("j1_drain_used_ignored", pkt_cnt, 3);
    check("j1_drain_no_done", done, 0);
    pl_empty = 1'b1;
    tick();
    pl_empty = 1'b0;
    check("j1_done", done, 1);
    check("j1_done_busy", busy, 1);
    tick();
    check("j1_done_pulse_end", done, 0);
    check("j1_idle_busy", busy, 0);
    check("j1_final_pkt", pkt_cnt, 3);
    check("j1_sel_held", sel_din, 8'h44);
    check("j1_err", err, 0);

    // Job 2: k=4, abort mid-RUN
    k_cfg = 3'd4; num_pkts = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("j2_cfg_strobes", {sel_wr, mask_wr}, 2'b11);
    check("j2_sel_din", sel_din, 8'hE4);
    check("j2_mask_din", mask_din, 8'h0F);
    tick();
    data_used = 1'b1;
    tick();
    data_used = 1'b0;
    check("j2_pkt1", pkt_cnt, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("j2_abort_busy", busy, 0);
    check("j2_abort_eng_rstn", eng_rstn, 0);
    check("j2_abort_done", done, 0);
    check("j2_abort_pkt", pkt_cnt, 1);
    check("j2_abort_calc_en", calc_en, 0);
    tick();
    check("j2_post_abort_eng_rstn", eng_rstn, 1);
    check("j2_post_abort_done", done, 0);

    // Invalid jobs
    k_cfg = 3'd3; num_pkts = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bad_k_err", err, 1);
    check("bad_k_busy", busy, 0);
    check("bad_k_eng_rstn", eng_rstn, 1);
    tick();
    check("bad_k_busy2", busy, 0);
    k_cfg = 3'd2; num_pkts = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bad_n_err", err, 1);
    check("bad_n_busy", busy, 0);
    check("bad_n_eng_rstn", eng_rstn, 1);

    // Job 3: valid start clears err; start during CLR ignored
    k_cfg = 3'd2; num_pkts = 16'd1;
    start = 1'b1;
    tick();
    check("j3_err_cleared", err, 0);
    check("j3_clr_eng_rstn", eng_rstn, 0);
    check("j3_pkt_cleared", pkt_cnt, 0);
    k_cfg = 3'd3;
    tick();
    start = 1'b0;
    check("j3_start_ignored_err", err, 0);
    check("j3_cfg_strobes", {sel_wr, mask_wr}, 2'b11);
    tick();
    check("j3_run_calc_en", calc_en, 1);
    data_used = 1'b1;
    tick();
    data_used = 1'b0;
    check("j3_pkt1", pkt_cnt, 1);
    check("j3_drain_calc_en", calc_en, 0);
`ifdef ENG_SEQ_TIMEOUT_EN
    repeat (63) tick();
    check("j3_to_no_done_yet", done, 0);
    check("j3_to_no_err_yet", err, 0);
    tick();
    check("j3_to_done", done, 1);
    check("j3_to_err", err, 1);
    check("j3_to_eng_rstn", eng_rstn, 0);
    tick();
    check("j3_to_idle_busy", busy, 0);
    check("j3_to_eng_rstn_rel", eng_rstn, 1);
`else
    repeat (100) tick();
    check("j3_wait_busy", busy, 1);
    check("j3_wait_no_done", done, 0);
    check("j3_wait_no_err", err, 0);
    pl_empty = 1'b1;
    tick();
    pl_empty = 1'b0;
    check("j3_done", done, 1);
    tick();
    check("j3_idle_busy", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
